// File: rtl/y86_bus_memory_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : y86_bus_memory_if
// Brief    : Core bus, byte loader and status signals of the y86 bus memory.
// Revision : 1.0 - initial release
// ============================================================================
interface y86_bus_memory_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_rdata;
    logic        cpu_rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic        addr_err;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re, ld_valid, ld_data, ld_last,
        output cpu_rdata, cpu_rst, ld_ready, rd_count, wr_count, addr_err
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, cpu_re, ld_valid, ld_data, ld_last,
        input  cpu_rdata, cpu_rst, ld_ready, rd_count, wr_count, addr_err
    );
endinterface
`default_nettype wire

// File: rtl/y86_bus_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : y86_bus_memory
// Brief    : Byte-array memory for the y86 core with boot loader and counters.
// Revision : 1.0 - initial release
// ============================================================================
module y86_bus_memory #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    y86_bus_memory_if.slave   bus
);
    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [15:0]   CNT_MAX  = 16'hFFFF;

    state_t        state_q;
    logic [AW-1:0] load_ptr_q;
    logic          cpu_rst_q;
    logic [15:0]   rd_count_q;
    logic [15:0]   wr_count_q;
    logic          addr_err_q;
    logic [7:0]    mem_q [DEPTH];

    logic [AW-1:0] w_idx0, w_idx1, w_idx2, w_idx3;
    logic          w_run, w_ld_fire, w_store, w_read, w_out_of_range;

    // Index arithmetic is AW bits wide, so multi-byte accesses wrap for free.
    assign w_idx0         = bus.cpu_addr[AW-1:0];
    assign w_idx1         = w_idx0 + AW'(1);
    assign w_idx2         = w_idx0 + AW'(2);
    assign w_idx3         = w_idx0 + AW'(3);
    assign w_run          = (state_q == RUN);
    assign w_ld_fire      = (state_q == LOAD) && bus.ld_valid;
    assign w_store        = w_run && bus.cpu_we;
    assign w_read         = w_run && bus.cpu_re;
    assign w_out_of_range = |bus.cpu_addr[31:AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            load_ptr_q <= '0;
            cpu_rst_q  <= 1'b1;
            rd_count_q <= '0;
            wr_count_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            // Follows the state one edge late, holding the core in reset a full cycle past the last byte.
            cpu_rst_q <= (state_q == LOAD);
            case (state_q)
                LOAD: begin
                    if (bus.ld_valid) begin
                        if (load_ptr_q != LAST_PTR) begin
                            load_ptr_q <= load_ptr_q + AW'(1);
                        end
                        if (bus.ld_last || (load_ptr_q == LAST_PTR)) begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.cpu_re && (rd_count_q != CNT_MAX)) begin
                        rd_count_q <= rd_count_q + 16'd1;
                    end
                    if (bus.cpu_we && (wr_count_q != CNT_MAX)) begin
                        wr_count_q <= wr_count_q + 16'd1;
                    end
                    if ((bus.cpu_re || bus.cpu_we) && w_out_of_range) begin
                        addr_err_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage has no reset so a reload can leave earlier contents in place.
    always_ff @(posedge clk) begin
        if (w_ld_fire) begin
            mem_q[load_ptr_q] <= bus.ld_data;
        end else if (w_store) begin
            mem_q[w_idx0] <= bus.cpu_wdata[7:0];
            mem_q[w_idx1] <= bus.cpu_wdata[15:8];
            mem_q[w_idx2] <= bus.cpu_wdata[23:16];
            mem_q[w_idx3] <= bus.cpu_wdata[31:24];
        end
    end

    assign bus.cpu_rdata = w_read ? {mem_q[w_idx3], mem_q[w_idx2], mem_q[w_idx1], mem_q[w_idx0]}
                                  : 32'h0;
    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.ld_ready  = (state_q == LOAD);
    assign bus.rd_count  = rd_count_q;
    assign bus.wr_count  = wr_count_q;
    assign bus.addr_err  = addr_err_q;
endmodule
`default_nettype wire

// File: tb/tb_y86_bus_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_y86_bus_memory
// Brief    : Self-checking bench for y86_bus_memory (vector table + read scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_y86_bus_memory;
    logic clk = 1'b0;
    logic rst;

    y86_bus_memory_if bus_if ();

    y86_bus_memory #(.DEPTH(256), .AW(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [15:0] exp_rd;
        logic [15:0] exp_wr;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [14];
    logic [7:0]  boot [3];
    logic [31:0] sb_q [$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_read(input string name);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: got %h, expected <scoreboard empty>", name, bus_if.cpu_rdata);
        end else begin
            exp = sb_q.pop_front();
            check(name, bus_if.cpu_rdata, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic bus_cycle(input logic re, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rdata,
                             input string name);
        bus_if.cpu_re    = re;
        bus_if.cpu_we    = we;
        bus_if.cpu_addr  = addr;
        bus_if.cpu_wdata = wdata;
        sb_q.push_back(exp_rdata);
        #2;
        check_read(name);
        tick();
    endtask

    task automatic bus_idle();
        bus_if.cpu_re    = 1'b0;
        bus_if.cpu_we    = 1'b0;
        bus_if.cpu_addr  = 32'h0;
        bus_if.cpu_wdata = 32'h0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        boot[0] = 8'h01; boot[1] = 8'hC0; boot[2] = 8'hF4;
        // re, we, addr, wdata, exp_rdata, rd_count, wr_count, addr_err (after the edge)
        vecs[0]  = '{1'b1, 1'b0, 32'd0,   32'h0,        32'h18F4C001, 16'd1,  16'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'd8,   32'hDEADBEEF, 32'h00000000, 16'd1,  16'd1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'd8,   32'h0,        32'hDEADBEEF, 16'd2,  16'd1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'd9,   32'h0,        32'h57DEADBE, 16'd3,  16'd1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'd254, 32'h11223344, 32'h00000000, 16'd3,  16'd2, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'd254, 32'h0,        32'h11223344, 16'd4,  16'd2, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'd0,   32'h0,        32'h18F41122, 16'd5,  16'd2, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'd16,  32'hCAFEF00D, 32'h88817A73, 16'd6,  16'd3, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'd16,  32'h0,        32'hCAFEF00D, 16'd7,  16'd3, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'd300, 32'h0,        32'h4C453E37, 16'd8,  16'd3, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'd4,   32'h0,        32'h342D261F, 16'd9,  16'd3, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 32'd276, 32'h01020304, 32'h00000000, 16'd9,  16'd4, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 32'd20,  32'h0,        32'h01020304, 16'd10, 16'd4, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 32'd20,  32'h0,        32'h00000000, 16'd10, 16'd4, 1'b1};

        rst = 1'b1;
        bus_idle();
        bus_if.ld_valid = 1'b0;
        bus_if.ld_data  = 8'h00;
        bus_if.ld_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_rst",  32'(bus_if.cpu_rst),  32'd1);
        check("rst_ld_ready", 32'(bus_if.ld_ready), 32'd1);
        check("rst_rd_count", 32'(bus_if.rd_count), 32'd0);
        check("rst_wr_count", 32'(bus_if.wr_count), 32'd0);
        check("rst_addr_err", 32'(bus_if.addr_err), 32'd0);
        rst = 1'b0;

        // Core accesses during LOAD are ignored entirely.
        bus_cycle(1'b1, 1'b1, 32'd300, 32'h12345678, 32'h0, "load_rdata_zero");
        bus_idle();
        check("load_no_rd_count", 32'(bus_if.rd_count), 32'd0);
        check("load_no_wr_count", 32'(bus_if.wr_count), 32'd0);
        check("load_no_addr_err", 32'(bus_if.addr_err), 32'd0);

        // Full-depth stream without ld_last: byte 257 must be refused.
        bus_if.ld_valid = 1'b1;
        for (int i = 0; i <= 256; i++) begin
            bus_if.ld_data = pat(i);
            #2;
            check($sformatf("stream_ready_%0d", i), 32'(bus_if.ld_ready), 32'(i < 256));
            if (i == 256) check("stream_cpu_rst_held", 32'(bus_if.cpu_rst), 32'd1);
            @(posedge clk);
            #1;
        end
        bus_if.ld_valid = 1'b0;
        check("stream_cpu_rst_fall", 32'(bus_if.cpu_rst), 32'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rerst_cpu_rst",  32'(bus_if.cpu_rst),  32'd1);
        check("rerst_ld_ready", 32'(bus_if.ld_ready), 32'd1);

        // Boot image 01 C0 F4 with ld_valid held high throughout.
        bus_if.ld_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            bus_if.ld_data = boot[j];
            bus_if.ld_last = (j == 2);
            #2;
            check($sformatf("boot_ready_%0d", j), 32'(bus_if.ld_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        bus_if.ld_data = 8'h55;
        bus_if.ld_last = 1'b0;
        check("boot_ready_drop", 32'(bus_if.ld_ready), 32'd0);
        check("boot_cpu_rst_hi", 32'(bus_if.cpu_rst),  32'd1);
        tick();
        check("boot_cpu_rst_lo", 32'(bus_if.cpu_rst),  32'd0);
        bus_if.ld_valid = 1'b0;

        for (int k = 0; k < 14; k++) begin
            bus_cycle(vecs[k].re, vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].exp_rdata,
                      $sformatf("vec%0d_rdata", k));
            check($sformatf("vec%0d_rd_count", k), 32'(bus_if.rd_count), 32'(vecs[k].exp_rd));
            check($sformatf("vec%0d_wr_count", k), 32'(bus_if.wr_count), 32'(vecs[k].exp_wr));
            check($sformatf("vec%0d_addr_err", k), 32'(bus_if.addr_err), 32'(vecs[k].exp_err));
        end

        // Saturate the read counter.
        bus_if.cpu_re   = 1'b1;
        bus_if.cpu_addr = 32'd4;
        repeat (70000) @(posedge clk);
        #1;
        sb_q.push_back(32'h342D261F);
        check_read("sat_rdata");
        check("sat_rd_count", 32'(bus_if.rd_count), 32'h0000FFFF);
        check("sat_wr_count", 32'(bus_if.wr_count), 32'd4);
        check("sat_addr_err", 32'(bus_if.addr_err), 32'd1);

        // Mid-run reset, then a one-byte reload; earlier stores must survive.
        bus_idle();
        rst = 1'b1;
        tick();
        check("mrst_rd_count", 32'(bus_if.rd_count), 32'd0);
        check("mrst_wr_count", 32'(bus_if.wr_count), 32'd0);
        check("mrst_addr_err", 32'(bus_if.addr_err), 32'd0);
        check("mrst_cpu_rst",  32'(bus_if.cpu_rst),  32'd1);
        check("mrst_ld_ready", 32'(bus_if.ld_ready), 32'd1);
        rst = 1'b0;
        bus_cycle(1'b1, 1'b0, 32'd8, 32'h0, 32'h0, "mrst_load_rdata");
        bus_idle();
        bus_if.ld_valid = 1'b1;
        bus_if.ld_data  = 8'hAA;
        bus_if.ld_last  = 1'b1;
        tick();
        bus_if.ld_valid = 1'b0;
        bus_if.ld_last  = 1'b0;
        check("reload_ready_drop", 32'(bus_if.ld_ready), 32'd0);
        tick();
        check("reload_cpu_rst_lo", 32'(bus_if.cpu_rst), 32'd0);
        bus_cycle(1'b1, 1'b0, 32'd8,  32'h0, 32'hDEADBEEF, "keep_rd8");
        bus_cycle(1'b1, 1'b0, 32'd16, 32'h0, 32'hCAFEF00D, "keep_rd16");
        bus_cycle(1'b1, 1'b0, 32'd0,  32'h0, 32'h18F411AA, "keep_rd0");
        bus_cycle(1'b1, 1'b0, 32'd20, 32'h0, 32'h01020304, "keep_rd20");
        bus_idle();
        check("keep_rd_count", 32'(bus_if.rd_count), 32'd4);
        check("keep_addr_err", 32'(bus_if.addr_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
